// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing the even/odd byte-bank ROM between fetch (F) and data (D) ports.
// Optional ROM_RANGE_CHECK_EN builds the per-request address range check and error response.
module rom_port_arbiter #(
  parameter int          SIZE    = 2048,
  parameter logic [15:0] ROMBASE = 16'h4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [15:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  output logic        d_err,
  output logic [14:0] read_addr_even,
  output logic [14:0] read_addr_odd,
  input  logic [7:0]  read_data_even,
  input  logic [7:0]  read_data_odd
);

  typedef enum logic {OWN_F = 1'b0, OWN_D = 1'b1} owner_e;

  owner_e      last_q, last_d;
  logic        f_vld_q, f_vld_d;
  logic        d_vld_q, d_vld_d;
  logic        lsb_q, lsb_d;
  logic [15:0] gnt_addr;
  logic [14:0] idx;
  logic [15:0] lane;
  logic [15:0] resp;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (f_req && d_req) begin
        f_gnt = (last_q == OWN_D);
        d_gnt = (last_q == OWN_F);
      end else begin
        f_gnt = f_req;
        d_gnt = d_req;
      end
    end
  end

  assign gnt_addr       = d_gnt ? d_addr : f_addr;
  assign idx            = gnt_addr[15:1];
  assign read_addr_odd  = idx;
  assign read_addr_even = gnt_addr[0] ? idx + 15'd1 : idx;

  always_comb begin
    last_d  = last_q;
    f_vld_d = f_gnt;
    d_vld_d = d_gnt;
    lsb_d   = lsb_q;
    if (f_gnt || d_gnt) begin
      last_d = d_gnt ? OWN_D : OWN_F;
      lsb_d  = gnt_addr[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= OWN_D;
      f_vld_q <= 1'b0;
      d_vld_q <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      last_q  <= last_d;
      f_vld_q <= f_vld_d;
      d_vld_q <= d_vld_d;
      lsb_q   <= lsb_d;
    end
  end

  // Reset in the response cycle kills the response of the previous grant.
  assign f_rvalid = f_vld_q & ~reset;
  assign d_rvalid = d_vld_q & ~reset;

  // An odd address puts its low byte in the odd bank and its high byte in the even bank.
  assign lane = lsb_q ? {read_data_even, read_data_odd} : {read_data_odd, read_data_even};

`ifdef ROM_RANGE_CHECK_EN
  localparam logic [16:0] RANGE_LO = {1'b0, ROMBASE};
  localparam logic [16:0] RANGE_HI = RANGE_LO + 17'(SIZE) - 17'd1;

  logic oor, oor_q;

  assign oor = ({1'b0, gnt_addr} < RANGE_LO) || (({1'b0, gnt_addr} + 17'd1) > RANGE_HI);

  always_ff @(posedge clk) begin
    if (reset) begin
      oor_q <= 1'b0;
    end else if (f_gnt || d_gnt) begin
      oor_q <= oor;
    end
  end

  assign resp  = oor_q ? 16'hFFFF : lane;
  assign f_err = f_rvalid & oor_q;
  assign d_err = d_rvalid & oor_q;
`else
  assign resp  = lane;
  assign f_err = 1'b0;
  assign d_err = 1'b0;
`endif

  assign f_rdata = f_rvalid ? resp : 16'h0000;
  assign d_rdata = d_rvalid ? resp : 16'h0000;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Randomized bench for rom_port_arbiter against a byte-addressed ROM and request-level model.
// Honours ROM_RANGE_CHECK_EN when defined for the build.
module tb_rom_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req;
  logic [15:0] f_addr, d_addr;
  logic        f_gnt, d_gnt, f_rvalid, d_rvalid, f_err, d_err;
  logic [15:0] f_rdata, d_rdata;
  logic [14:0] read_addr_even, read_addr_odd;
  logic [7:0]  read_data_even, read_data_odd;

  rom_port_arbiter #(.SIZE(2048), .ROMBASE(16'h4000)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .read_addr_even(read_addr_even), .read_addr_odd(read_addr_odd),
    .read_data_even(read_data_even), .read_data_odd(read_data_odd)
  );

  always #5 clk = ~clk;

  // Flat byte-addressed ROM image; each bank returns its byte one clock after the address.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    read_data_even <= mem[{read_addr_even, 1'b0}];
    read_data_odd  <= mem[{read_addr_odd, 1'b1}];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: outstanding requests, most recent winner, response due next cycle.
  bit          f_act, d_act;
  logic [15:0] f_a, d_a;
  bit          last_was_d;
  bit          due_f, due_d;
  logic [15:0] due_a;

  function automatic bit in_range(input logic [15:0] a);
    int lo = 32'h4000;
    int hi = 32'h4000 + 2048 - 1;
    return (int'(a) >= lo) && (int'(a) + 1 <= hi);
  endfunction

  function automatic logic [15:0] exp_word(input logic [15:0] a);
    logic [15:0] a1 = a + 16'd1;
`ifdef ROM_RANGE_CHECK_EN
    if (!in_range(a)) return 16'hFFFF;
`endif
    return {mem[a1], mem[a]};
  endfunction

  function automatic bit exp_err(input logic [15:0] a);
`ifdef ROM_RANGE_CHECK_EN
    return !in_range(a);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input logic rst);
    bit          gf, gd;
    logic [15:0] a, ea;
    @(negedge clk);
    reset  = rst;
    f_req  = f_act;
    f_addr = f_a;
    d_req  = d_act;
    d_addr = d_a;
    #1;
    gf = !rst && f_act && (!d_act || last_was_d);
    gd = !rst && d_act && (!f_act || !last_was_d);
    check_eq("f_gnt", f_gnt, gf);
    check_eq("d_gnt", d_gnt, gd);
    a = gd ? d_a : f_a;
    if (gf || gd) begin
      ea = a[0] ? a + 16'd1 : a;
      check_eq("addr_odd", read_addr_odd, a >> 1);
      check_eq("addr_even", read_addr_even, ea >> 1);
    end
    check_eq("f_rvalid", f_rvalid, due_f && !rst);
    check_eq("d_rvalid", d_rvalid, due_d && !rst);
    check_eq("f_rdata", f_rdata, (due_f && !rst) ? exp_word(due_a) : 16'h0000);
    check_eq("d_rdata", d_rdata, (due_d && !rst) ? exp_word(due_a) : 16'h0000);
    check_eq("f_err", f_err, (due_f && !rst) ? exp_err(due_a) : 1'b0);
    check_eq("d_err", d_err, (due_d && !rst) ? exp_err(due_a) : 1'b0);
    due_f = gf;
    due_d = gd;
    due_a = a;
    if (gf || gd) last_was_d = gd;
    if (gf) f_act = 0;
    if (gd) d_act = 0;
    if (rst) begin
      last_was_d = 1;
      due_f = 0;
      due_d = 0;
    end
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 3))
      0: return 16'($urandom);
      1: return 16'h4000 + 16'($urandom_range(0, 2047));
      2: return 16'h47F8 + 16'($urandom_range(0, 15));
      default: return 16'h3FFC + 16'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h4000] = 8'h12;
    mem[16'h4001] = 8'h34;
    mem[16'h4002] = 8'h56;
    reset = 1; f_req = 0; d_req = 0; f_addr = 0; d_addr = 0;
    last_was_d = 1; due_f = 0; due_d = 0; due_a = 0;

    // Reset with both requesting, then aligned fetch and unaligned data read.
    f_act = 1; f_a = 16'h4000;
    d_act = 1; d_a = 16'h4001;
    repeat (3) step(1);
    step(0);
    check_eq("tp_first_fgnt_after_reset", f_gnt, 1'b1);
    check_eq("tp_aligned_even", read_addr_even, 15'h2000);
    step(0);
    check_eq("tp_aligned_rdata", f_rdata, 16'h3412);
    check_eq("tp_unaligned_odd", read_addr_odd, 15'h2000);
    check_eq("tp_unaligned_even", read_addr_even, 15'h2001);
    step(0);
    check_eq("tp_unaligned_rdata", d_rdata, 16'h5634);

    // Six cycles of contention alternate F, D, F, ...
    for (int i = 0; i < 6; i++) begin
      if (!f_act) begin f_act = 1; f_a = pick_addr(); end
      if (!d_act) begin d_act = 1; d_a = pick_addr(); end
      step(0);
      check_eq("tp_rr_order", f_gnt, (i % 2) == 0);
    end
    step(0);
    step(0);

    // Wrap and range boundaries.
    f_act = 1; f_a = 16'hFFFF;
    step(0);
    check_eq("tp_wrap_even", read_addr_even, 15'h0000);
    check_eq("tp_wrap_odd", read_addr_odd, 15'h7FFF);
    f_act = 1; f_a = 16'h47FE; step(0);
`ifdef ROM_RANGE_CHECK_EN
    check_eq("tp_ffff_err", f_err, 1'b1);
    check_eq("tp_ffff_rdata", f_rdata, 16'hFFFF);
`endif
    f_act = 1; f_a = 16'h47FF; step(0);
    f_act = 1; f_a = 16'h3FFF; step(0);
    step(0);

    // Reset in the cycle after a grant cancels its response.
    f_act = 1; f_a = 16'h4010;
    step(0);
    step(1);
    check_eq("tp_reset_kills_rvalid", f_rvalid, 1'b0);
    step(0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if (!f_act && $urandom_range(0, 2) != 0) begin f_act = 1; f_a = pick_addr(); end
      if (!d_act && $urandom_range(0, 2) != 0) begin d_act = 1; d_a = pick_addr(); end
      step($urandom_range(0, 59) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
